led_pattern_driver: RTL and testbench

- Downstream consumer of the 3-bit LED counter.
- Turns the counter value into an 8-LED bar pattern, with a button-selected display mode and PWM brightness.
- Sits between the counter and the board LED pins.
- Runs on the same clk as the counter.

---
 rtl/led_pkg.sv | 24 ++
 rtl/button_sync_edge.sv | 30 +++
 rtl/led_pattern_driver.sv | 82 ++++++++
 tb/tb_led_pattern_driver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
`default_nettype none
// led_pkg: display-mode encoding and defaults shared by the LED pattern path.
package led_pkg;

    localparam int DEFAULT_COUNT_W = 3;

    typedef enum logic [1:0] {
        MODE_BIN    = 2'd0,
        MODE_ONEHOT = 2'd1,
        MODE_THERMO = 2'd2,
        MODE_BLINK  = 2'd3
    } led_mode_e;

    function automatic led_mode_e next_mode(input led_mode_e m);
        case (m)
            MODE_BIN:    return MODE_ONEHOT;
            MODE_ONEHOT: return MODE_THERMO;
            MODE_THERMO: return MODE_BLINK;
            default:     return MODE_BIN;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_sync_edge.sv
`default_nettype none
// button_sync_edge: two-flop synchroniser for a raw pushbutton plus a
// single-cycle pulse on each synchronised rising edge.
module button_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= btn_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule
`default_nettype wire

// File: rtl/led_pattern_driver.sv
`default_nettype none
// led_pattern_driver: turns the upstream LED count into a bar pattern with a
// button-stepped display mode and PWM brightness, registered onto the pins.
module led_pattern_driver
    import led_pkg::*;
#(
    parameter int COUNT_W  = DEFAULT_COUNT_W,
    parameter int PWM_BITS = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [COUNT_W-1:0]        led_count,
    input  logic                      mode_btn,
    input  logic [PWM_BITS-1:0]       duty,
    output logic [(2**COUNT_W)-1:0]   leds,
    output logic [1:0]                mode,
    output logic                      step
);

    localparam int NUM_LEDS = 2**COUNT_W;

    logic [COUNT_W-1:0]  count_q;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                blink_phase;
    led_mode_e           mode_q;
    logic                mode_rise;
    logic                pwm_on;
    logic [NUM_LEDS-1:0] pattern;

    button_sync_edge u_mode_btn (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_in  (mode_btn),
        .rise    (mode_rise)
    );

    // Full-scale duty must mean always on, which a plain compare cannot reach.
    assign pwm_on = (duty == {PWM_BITS{1'b1}}) | (pwm_cnt < duty);

    always_comb begin
        pattern = '0;
        case (mode_q)
            MODE_BIN:    pattern = NUM_LEDS'(count_q);
            MODE_ONEHOT: pattern = NUM_LEDS'(1) << count_q;
            MODE_THERMO: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    pattern[i] = (i <= int'(count_q));
                end
            end
            MODE_BLINK:  pattern = blink_phase ? (NUM_LEDS'(1) << count_q) : '0;
            default:     pattern = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            step        <= 1'b0;
            pwm_cnt     <= '0;
            leds        <= '0;
            mode_q      <= MODE_BIN;
            blink_phase <= 1'b0;
        end else begin
            count_q <= led_count;
            step    <= (led_count != count_q);
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            leds    <= pattern & {NUM_LEDS{pwm_on}};
            // A mode change restarts blinking from the dark phase, even if a
            // count step lands on the same edge.
            if (mode_rise) begin
                mode_q      <= next_mode(mode_q);
                blink_phase <= 1'b0;
            end else if (step) begin
                blink_phase <= ~blink_phase;
            end
        end
    end

    assign mode = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_driver.sv
`default_nettype none
// tb_led_pattern_driver: cycle scoreboard against a behavioural model plus
// directed checks of reset, mode stepping, blink, PWM and collision cases.
module tb_led_pattern_driver;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       mode_btn = 1'b0;
    logic [2:0] led_count = 3'd0;
    logic [3:0] duty = 4'd0;
    logic [7:0] leds;
    logic [1:0] mode;
    logic       step;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] leds;
        logic [1:0] mode;
        logic       step;
    } exp_t;

    exp_t sb_q[$];

    led_pattern_driver #(.COUNT_W(3), .PWM_BITS(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .led_count (led_count),
        .mode_btn  (mode_btn),
        .duty      (duty),
        .leds      (leds),
        .mode      (mode),
        .step      (step)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input int hold);
        mode_btn = 1'b1;
        cyc(hold);
        mode_btn = 1'b0;
        cyc(6);
    endtask

    // Behavioural reference model
    logic       m_s1, m_s2, m_s3, m_step, m_phase;
    logic [2:0] m_count;
    logic [1:0] m_mode;
    logic [3:0] m_pwm;
    logic       m_rise, m_pwm_on;
    logic [7:0] m_pat;

    always_comb begin
        m_rise   = m_s2 & ~m_s3;
        m_pwm_on = (duty == 4'hF) || (m_pwm < duty);
        m_pat    = 8'h00;
        case (m_mode)
            2'd0:    m_pat = {5'b00000, m_count};
            2'd1:    m_pat = 8'h01 << m_count;
            2'd2:    m_pat = 8'hFF >> (3'd7 - m_count);
            default: m_pat = m_phase ? (8'h01 << m_count) : 8'h00;
        endcase
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_s1    <= 1'b0;
            m_s2    <= 1'b0;
            m_s3    <= 1'b0;
            m_step  <= 1'b0;
            m_phase <= 1'b0;
            m_count <= 3'd0;
            m_mode  <= 2'd0;
            m_pwm   <= 4'd0;
            sb_q.delete();
        end else begin
            m_s1    <= mode_btn;
            m_s2    <= m_s1;
            m_s3    <= m_s2;
            m_count <= led_count;
            m_step  <= (led_count != m_count);
            m_pwm   <= m_pwm + 4'd1;
            m_mode  <= m_rise ? m_mode + 2'd1 : m_mode;
            m_phase <= m_rise ? 1'b0 : (m_step ? ~m_phase : m_phase);
            sb_q.push_back({(m_pwm_on ? m_pat : 8'h00),
                            (m_rise ? m_mode + 2'd1 : m_mode),
                            (led_count != m_count)});
        end
    end

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (reset_n) begin
            check("sb_depth", sb_q.size(), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_leds", leds, e.leds);
                check("sb_mode", mode, e.mode);
                check("sb_step", step, e.step);
            end
        end
    end

    logic [3:0] duty_v [3] = '{4'd0, 4'd4, 4'd15};
    int         hits_v [3] = '{0, 8, 32};

    initial begin
        int steps;
        int hits;
        int nz;

        // Reset held while clock and button toggle
        repeat (3) begin
            @(negedge clk);
            mode_btn = ~mode_btn;
        end
        @(negedge clk);
        mode_btn = 1'b0;
        check("rst_leds", leds, 8'h00);
        check("rst_mode", mode, 2'd0);
        check("rst_step", step, 1'b0);
        cyc(1);
        duty      = 4'hF;
        led_count = 3'd3;
        reset_n   = 1'b1;
        cyc(2);
        check("rel_leds", leds, 8'h03);

        // BIN tracking and step pulses
        led_count = 3'd0;
        cyc(4);
        steps = 0;
        for (int k = 1; k <= 8; k++) begin
            led_count = 3'(k);
            for (int c = 0; c < 4; c++) begin
                cyc(1);
                if (step) steps++;
            end
            check("bin_leds", leds, k % 8);
        end
        check("step_pulses", steps, 8);

        // Mode sequence
        led_count = 3'd5;
        cyc(4);
        press(5);
        check("onehot_mode", mode, 2'd1);
        check("onehot_leds", leds, 8'h20);
        press(5);
        check("thermo_mode", mode, 2'd2);
        check("thermo_leds", leds, 8'h3F);
        press(5);
        check("blink_mode", mode, 2'd3);
        check("blink_leds0", leds, 8'h00);
        led_count = 3'd4; cyc(4); check("blink_leds1", leds, 8'h10);
        led_count = 3'd5; cyc(4); check("blink_leds2", leds, 8'h00);
        led_count = 3'd6; cyc(4); check("blink_leds3", leds, 8'h40);
        led_count = 3'd5; cyc(4); check("blink_leds4", leds, 8'h00);
        press(5);
        check("wrap_mode", mode, 2'd0);
        check("wrap_leds", leds, 8'h05);
        press(50);
        check("hold_mode", mode, 2'd1);
        check("hold_leds", leds, 8'h20);

        // PWM in THERMO at full count
        press(5);
        check("pwm_mode", mode, 2'd2);
        led_count = 3'd7;
        cyc(4);
        for (int d = 0; d < 3; d++) begin
            duty = duty_v[d];
            cyc(2);
            hits = 0;
            nz   = 0;
            for (int c = 0; c < 32; c++) begin
                cyc(1);
                if (leds == 8'hFF) hits++;
                if (leds != 8'h00) nz++;
            end
            check("pwm_full", hits, hits_v[d]);
            check("pwm_lit", nz, hits_v[d]);
        end

        // Mode rise coinciding with a count step in BLINK
        duty = 4'hF;
        press(5);
        check("col_pre_mode", mode, 2'd3);
        check("col_pre_phase", dut.blink_phase, 1'b0);
        mode_btn = 1'b1;
        cyc(1);
        led_count = 3'd5;
        cyc(1);
        check("col_step", step, 1'b1);
        check("col_rise", dut.mode_rise, 1'b1);
        cyc(1);
        check("col_mode", mode, 2'd0);
        check("col_phase", dut.blink_phase, 1'b0);
        cyc(3);
        mode_btn = 1'b0;
        cyc(6);
        check("col_leds", leds, 8'h05);

        // Asynchronous reset in the middle of BLINK
        press(5);
        press(5);
        press(5);
        check("mid_mode", mode, 2'd3);
        led_count = 3'd4;
        cyc(4);
        check("mid_leds", leds, 8'h10);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_leds", leds, 8'h00);
        check("async_mode", mode, 2'd0);
        check("async_step", step, 1'b0);
        cyc(2);
        reset_n = 1'b1;
        cyc(4);
        check("post_leds", leds, 8'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
